// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - RV32I load/store funct3 encodings (instr[14:12]).
//   - Responder FSM state type.
//   - Legality helpers for load and store funct3 values.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   // Loads accept signed and unsigned byte/half plus word.
   function automatic logic load_f3_ok(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   // Stores have no unsigned variants.
   function automatic logic store_f3_ok(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W};
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational lane formatting for byte/half/word accesses.
//   funct3    : access size (bits [1:0]) and unsigned flag (bit 2)
//   addr_lo   : byte offset within the 32-bit word
//   wdata     : right-aligned store data
//   rword     : word currently held in storage at the access index
//   byte_en   : lanes written by a store
//   wword     : store data replicated into every lane position
//   load_data : selected lane(s) shifted to bit 0 and extended
//   misalign  : half on an odd address, or word not on a 4-byte boundary
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wword,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic [31:0] shifted;

   assign shifted = rword >> {addr_lo, 3'b000};

   // NOTE: every output gets a default before the case so no path leaves
   // one unassigned; otherwise a latch is inferred.
   always_comb begin
      byte_en   = 4'b0000;
      wword     = wdata;
      load_data = rword;
      misalign  = 1'b0;
      case (funct3[1:0])
         2'b00: begin
            byte_en   = 4'b0001 << addr_lo;
            wword     = {4{wdata[7:0]}};
            load_data = funct3[2] ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wword     = {2{wdata[15:0]}};
            load_data = funct3[2] ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
            misalign  = addr_lo[0];
         end
         2'b10: begin
            byte_en  = 4'b1111;
            misalign = |addr_lo;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core data port.
//   One request at a time over a valid/ready handshake, an optional run of
//   wait states, then a held response until the requester takes it.
//   clk, n_rst          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only while IDLE)
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   req_funct3          : RV32I size/sign encoding
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : extended load data; 0 for stores and errors
//   rsp_err             : misaligned, out-of-range or illegal access
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
   localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);

   dmem_state_t      state;
   logic [CNT_W-1:0] wait_cnt;

   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [2:0]  lat_funct3;

   logic        acc_we;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [2:0]  acc_funct3;

   logic [31:0]      off;
   logic [IDX_W-1:0] idx;
   logic             out_of_range;
   logic             f3_bad;
   logic             acc_err;
   logic             do_access;
   logic [31:0]      rsp_rdata_nxt;

   logic [3:0]  byte_en;
   logic [31:0] wword;
   logic [31:0] load_data;
   logic        misalign;
   logic [31:0] rword;

   logic [31:0] mem [DEPTH_WORDS];

   assign req_ready = (state == IDLE);

   // With no wait states the access happens on the acceptance edge itself,
   // before the latches hold the request, so decode from the live inputs
   // while IDLE and from the latched copy otherwise.
   always_comb begin
      acc_we     = lat_we;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
      acc_funct3 = lat_funct3;
      if (state == IDLE) begin
         acc_we     = req_we;
         acc_addr   = req_addr;
         acc_wdata  = req_wdata;
         acc_funct3 = req_funct3;
      end
   end

   // Unsigned subtraction folds addresses below BASE_ADDR into huge offsets,
   // so one compare covers both ends of the window.
   assign off          = acc_addr - BASE_ADDR;
   assign idx          = off[IDX_W+1:2];
   assign out_of_range = (off >> (IDX_W + 2)) != 32'h0;
   assign rword        = mem[idx];

   assign f3_bad  = acc_we ? !store_f3_ok(acc_funct3) : !load_f3_ok(acc_funct3);
   assign acc_err = f3_bad | misalign | out_of_range;

   assign do_access = ((state == IDLE) && req_valid && ZERO_WAIT) ||
                      ((state == WAIT) && (wait_cnt == '0));

   assign rsp_rdata_nxt = (acc_we || acc_err) ? 32'h0 : load_data;

   dmem_lane_fmt u_lane_fmt (
      .funct3    (acc_funct3),
      .addr_lo   (acc_addr[1:0]),
      .wdata     (acc_wdata),
      .rword     (rword),
      .byte_en   (byte_en),
      .wword     (wword),
      .load_data (load_data),
      .misalign  (misalign)
   );

   // NOTE: storage has no reset; clearing a RAM is costly and contents are
   // undefined until written. A reset during WAIT forces state to IDLE at
   // once, so do_access is low and an aborted store never lands here.
   always_ff @(posedge clk) begin
      if (do_access && acc_we && !acc_err) begin
         for (int l = 0; l < 4; l++) begin
            if (byte_en[l]) mem[idx][8*l +: 8] <= wword[8*l +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         lat_we     <= 1'b0;
         lat_addr   <= 32'h0;
         lat_wdata  <= 32'h0;
         lat_funct3 <= 3'b000;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 32'h0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we     <= req_we;
                  lat_addr   <= req_addr;
                  lat_wdata  <= req_wdata;
                  lat_funct3 <= req_funct3;
                  if (ZERO_WAIT) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rsp_rdata_nxt;
                     rsp_err   <= acc_err;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rsp_rdata_nxt;
                  rsp_err   <= acc_err;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
//   A byte-addressed model predicts each response when the request is
//   driven; a monitor pops and compares when the response handshake fires.
module tb_dmem_responder;

   localparam int unsigned DEPTH_WORDS = 1024;
   localparam int unsigned WAIT_CYCLES = 2;
   localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
   localparam int          LAT         = WAIT_CYCLES + 1;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [2:0]  req_funct3 = 3'b000;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;
   int hs_count = 0;
   int sent_hs  = 0;
   logic [31:0] last_rdata = 32'h0;

   logic [32:0] exp_q[$];
   string       tag_q[$];
   logic [7:0]  mdl [0:4*DEPTH_WORDS-1];

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .WAIT_CYCLES (WAIT_CYCLES),
      .BASE_ADDR   (BASE_ADDR)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: returns {err, rdata} and applies legal stores.
   function automatic logic [32:0] model(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [2:0] f3);
      logic [31:0] o;
      logic [31:0] v;
      int          sz;
      logic        legal;
      logic        err;
      o = addr - BASE_ADDR;
      case (f3)
         3'b000, 3'b100: sz = 1;
         3'b001, 3'b101: sz = 2;
         3'b010:         sz = 4;
         default:        sz = 0;
      endcase
      legal = we ? (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) : (sz != 0);
      err = !legal || (o >= 32'(4 * DEPTH_WORDS));
      if (!err && (addr % 32'(sz)) != 0) err = 1'b1;
      if (err) return {1'b1, 32'h0};
      if (we) begin
         for (int i = 0; i < sz; i++) mdl[o + 32'(i)] = wdata[8*i +: 8];
         return {1'b0, 32'h0};
      end
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mdl[o + 32'(i)];
      if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
      if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
      return {1'b0, v};
   endfunction

   // Monitor: a response is taken on the edge after valid&&ready is seen.
   always @(negedge clk) begin
      logic [32:0] e;
      string       t;
      if (n_rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, "_err"}, {31'h0, rsp_err}, {31'h0, e[32]});
            check({t, "_rdata"}, rsp_rdata, e[31:0]);
            last_rdata = rsp_rdata;
            hs_count++;
         end
      end
   end

   // Drive a request and hold it until accepted; track=0 skips the
   // scoreboard for requests that are expected to be aborted.
   task automatic send(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3, input bit track);
      bit acc;
      int n;
      if (track) begin
         exp_q.push_back(model(we, addr, wdata, f3));
         tag_q.push_back(tag);
      end
      req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
      req_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
         acc = req_ready;
         @(posedge clk); #1;
         n++;
      end
      req_valid = 1'b0;
      sent_hs = hs_count;
      if (!acc) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
   endtask

   // Called at #1 after the acceptance edge. Latency counts edges from the
   // acceptance edge (inclusive) to the one that raises rsp_valid.
   task automatic wait_rsp(input string tag);
      int edges;
      edges = 1;
      while (!rsp_valid && edges < 50) begin
         @(posedge clk); #1;
         edges++;
      end
      if (!rsp_valid) begin
         check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_lat"}, 32'(edges), 32'(LAT));
         if (rsp_ready) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3);
      send(tag, we, addr, wdata, f3, 1'b1);
      wait_rsp(tag);
   endtask

   initial begin
      int hs_before;
      int acc_hs;

      // Reset state
      #12;
      check("rst_req_ready", {31'h0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err",   {31'h0, rsp_err}, 32'd0);
      n_rst = 1'b1;
      @(posedge clk); #1;

      // 1: word store then load
      txn("t1_sw", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
      txn("t1_lw", 1'b0, 32'h10, 32'h0, 3'b010);
      check("t1_lw_lit", last_rdata, 32'hDEADBEEF);

      // 2: byte store, signed/unsigned byte loads, merged word
      txn("t2_sb",  1'b1, 32'h13, 32'h00000080, 3'b000);
      txn("t2_lb",  1'b0, 32'h13, 32'h0, 3'b000);
      check("t2_lb_lit", last_rdata, 32'hFFFFFF80);
      txn("t2_lbu", 1'b0, 32'h13, 32'h0, 3'b100);
      check("t2_lbu_lit", last_rdata, 32'h00000080);
      txn("t2_lw",  1'b0, 32'h10, 32'h0, 3'b010);
      check("t2_lw_lit", last_rdata, 32'h80ADBEEF);

      // Half store and signed/unsigned half loads on the upper lanes
      txn("h_sh",  1'b1, 32'h16, 32'hABCD8001, 3'b001);
      txn("h_lh",  1'b0, 32'h16, 32'h0, 3'b001);
      check("h_lh_lit", last_rdata, 32'hFFFF8001);
      txn("h_lhu", 1'b0, 32'h16, 32'h0, 3'b101);

      // 3: misaligned accesses fault and change nothing
      txn("t3_lh_mis", 1'b0, 32'h11, 32'h0, 3'b001);
      txn("t3_sw_mis", 1'b1, 32'h12, 32'h11111111, 3'b010);
      txn("t3_lw",     1'b0, 32'h10, 32'h0, 3'b010);

      // 4: out-of-range and illegal funct3
      txn("t4_oor",     1'b0, BASE_ADDR + 32'(4 * DEPTH_WORDS), 32'h0, 3'b010);
      txn("t4_oor_top", 1'b1, 32'hFFFF_FFFC, 32'h22222222, 3'b010);
      txn("t4_ld011",   1'b0, 32'h10, 32'h0, 3'b011);
      txn("t4_st100",   1'b1, 32'h10, 32'h33333333, 3'b100);
      txn("t4_lw",      1'b0, 32'h10, 32'h0, 3'b010);

      // 5: backpressure on the response while a second request waits
      rsp_ready = 1'b0;
      send("t5_a", 1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
      wait_rsp("t5_a");
      hs_before = 0;
      fork
         send("t5_b", 1'b0, 32'h13, 32'h0, 3'b100, 1'b1);
         begin
            for (int c = 0; c < 5; c++) begin
               @(posedge clk); #1;
               check("t5_hold_valid", {31'h0, rsp_valid}, 32'd1);
               check("t5_hold_rdata", rsp_rdata, 32'h80ADBEEF);
               check("t5_hold_err",   {31'h0, rsp_err}, 32'd0);
               check("t5_busy_ready", {31'h0, req_ready}, 32'd0);
            end
            hs_before = hs_count;
            rsp_ready = 1'b1;
         end
      join
      acc_hs = sent_hs;
      check("t5_order", 32'(acc_hs), 32'(hs_before + 1));
      wait_rsp("t5_b");

      // 6: reset during WAIT aborts a pending store
      txn("t6_sw_init", 1'b1, 32'h20, 32'hCAFEF00D, 3'b010);
      send("t6_sw_abort", 1'b1, 32'h20, 32'h12345678, 3'b010, 1'b0);
      check("t6_in_wait", {31'h0, req_ready}, 32'd0);
      #2 n_rst = 1'b0;
      #1;
      check("t6_rst_ready", {31'h0, req_ready}, 32'd1);
      check("t6_rst_valid", {31'h0, rsp_valid}, 32'd0);
      check("t6_rst_rdata", rsp_rdata, 32'h0);
      check("t6_rst_err",   {31'h0, rsp_err}, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk); #1;
      txn("t6_lw", 1'b0, 32'h20, 32'h0, 3'b010);
      check("t6_lw_lit", last_rdata, 32'hCAFEF00D);

      repeat (3) @(posedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that serves the core's load/store requests. It is the memory-side end of the core's data port, which carries MemRead, MemWr, ALU address and store data.
- Valid/ready request and response handshake.
- Configurable wait states.
- RV32I byte, half and word sizing with sign or zero extension on loads.
- Error reporting for misaligned, out-of-range and illegal accesses.
- Sits between the core datapath and a word-organised storage array. It replaces the single-cycle combinational memory path, so the core can later tolerate stalls.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in storage; power of two.
WAIT_CYCLES, 2, extra cycles between request acceptance and response; 0 is legal.
BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned.

Ports:
clk  input  1  clock
n_rst  input  1  reset, asynchronous, active-low
req_valid  input  1  requester presents a transaction
req_ready  output  1  responder can accept (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_funct3  input  3  instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
rsp_valid  output  1  response available
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  load result, extended; 0 for stores and errors
rsp_err  output  1  access faulted; no state changed

Behaviour:
- Reset values:
  - state = IDLE, wait_cnt = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 1 after reset, because it decodes from state.
  - Storage contents are not reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready = 1. On req_valid && req_ready, latch we/addr/wdata/funct3. If WAIT_CYCLES = 0, go to RESP; otherwise go to WAIT with wait_cnt = WAIT_CYCLES-1.
  - WAIT: req_ready = 0. Decrement wait_cnt. When wait_cnt == 0, go to RESP.
  - RESP entry edge: perform the access and register rsp_rdata/rsp_err. rsp_valid is high throughout RESP.
  - RESP: hold rsp_valid/rsp_rdata/rsp_err stable until rsp_valid && rsp_ready is sampled, then go to IDLE and clear rsp_valid.
- Latency and throughput:
  - rsp_valid rises WAIT_CYCLES+1 edges after the acceptance edge.
  - At most one transaction is outstanding.
  - Minimum period is WAIT_CYCLES+2 cycles with rsp_ready tied high.
- Request handshake: req_valid while busy is ignored; the requester holds the request. req_ready never depends combinationally on req_valid.
- Decode, using the latched request:
  - off = addr - BASE_ADDR; idx = off[log2(DEPTH_WORDS)+1:2].
  - Out-of-range when off >= 4*DEPTH_WORDS, including the wrap below BASE_ADDR.
- Error conditions (set rsp_err = 1, no write, rdata = 0):
  - H/HU access with addr[0] = 1.
  - W access with addr[1:0] != 0.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
  - Out-of-range address.
- Stores: lane byte-enable from addr[1:0].
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged. rsp_rdata = 0.
- Loads: read word idx, shift the selected lane(s) to bit 0.
  - B/H sign-extend; BU/HU zero-extend.
  - W passes the word through.
- Read-after-write: a load accepted after a store's response returns the stored data. No forwarding is needed beyond this, because the responder is never concurrent.
- Reset mid-operation:
  - An asynchronous n_rst in WAIT aborts the transaction; a pending store is NOT performed.
  - In RESP the store has already committed; only the response is dropped.
- rsp_ready high while no response is pending has no effect.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum dmem_state_t {IDLE, WAIT, RESP}.
- Sub-module dmem_lane_fmt (combinational):
  - Inputs: funct3, addr[1:0], wdata, rword.
  - Outputs: byte_en[3:0], wword (lane-replicated store data), load_data (extended), misalign.
- Storage is an inferred register array in dmem_responder.

Test Plan:
1. Reset, then SW 0xDEADBEEF to 0x10, then LW 0x10, with WAIT_CYCLES=2. Store: rsp_valid 3 edges after acceptance, rsp_err=0. Load: rsp_rdata=0xDEADBEEF.
2. SB 0x80 to 0x13, then LB 0x13 and LBU 0x13. LB returns 0xFFFFFF80; LBU returns 0x00000080; LW 0x10 returns 0x80ADBEEF.
3. LH 0x11 and SW 0x12. Both return rsp_err=1, rsp_rdata=0; a following LW 0x10 is unchanged.
4. LW at BASE_ADDR+4*DEPTH_WORDS, and load funct3=011. Both return rsp_err=1.
5. Hold rsp_ready=0 for 5 cycles in RESP while driving req_valid. Response stays stable, req_ready=0, and the second request is accepted only after the response handshake.
6. Assert n_rst during WAIT of SW 0x12345678 to 0x20. All outputs return to reset values; a subsequent LW 0x20 returns the prior contents.
